// File: rtl/dht11_sensor_interface.sv
// Single-wire DHT11 reader: issues the host start pulse, times the sensor's
// response and 40 data bits, verifies the checksum and publishes the frame.
module dht11_sensor_interface #(
  parameter int TICKS_PER_US  = 50,
  parameter int START_LOW_US  = 18000,
  parameter int BIT_THRESH_US = 40,
  parameter int TIMEOUT_US    = 200
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        enable,
  inout  wire         dht_data,
  output logic [39:0] data_sensor,
  output logic        data_valid,
  output logic        error,
  output logic        busy,
  output logic [3:0]  fsm_state
);

  typedef enum logic [3:0] {
    IDLE, START_LOW, RELEASE, RESP_LOW, RESP_HIGH,
    BIT_LOW, BIT_HIGH, CHECK, DONE, ERROR
  } state_t;

  localparam int TICK_W    = (TICKS_PER_US > 1) ? $clog2(TICKS_PER_US) : 1;
  localparam int PHASE_MAX = (START_LOW_US > TIMEOUT_US) ? START_LOW_US : TIMEOUT_US;
  localparam int PHASE_W   = $clog2(PHASE_MAX + 1);

  state_t              state;
  logic [TICK_W-1:0]   tick;
  logic [PHASE_W-1:0]  phase;
  logic [5:0]          bit_idx;
  logic [39:0]         shift_reg;
  logic                drive_low;
  logic                enable_prev;
  logic [1:0]          sync_q;
  logic                line_prev;
  logic                line;
  logic                rise;
  logic                fall;
  logic                us_tick;
  logic                timed_out;
  logic                start;
  logic [7:0]          sum;

  // Host only ever pulls the line low; the external pull-up provides the high.
  assign dht_data  = drive_low ? 1'b0 : 1'bz;
  assign fsm_state = state;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync_q    <= 2'b11;
      line_prev <= 1'b1;
    end else begin
      sync_q    <= {sync_q[0], dht_data};
      line_prev <= sync_q[1];
    end
  end

  assign line      = sync_q[1];
  assign rise      = line & ~line_prev;
  assign fall      = ~line & line_prev;
  assign us_tick   = (tick == TICK_W'(TICKS_PER_US - 1));
  assign timed_out = us_tick && (phase >= PHASE_W'(TIMEOUT_US - 1));
  assign start     = enable && !enable_prev;
  assign sum       = shift_reg[39:32] + shift_reg[31:24] + shift_reg[23:16] + shift_reg[15:8];

  // Phase counters restart on every transition, so each state measures whole
  // microseconds from its own entry.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      tick        <= '0;
      phase       <= '0;
      bit_idx     <= '0;
      shift_reg   <= '0;
      data_sensor <= '0;
      data_valid  <= 1'b0;
      error       <= 1'b0;
      busy        <= 1'b0;
      drive_low   <= 1'b0;
      enable_prev <= 1'b0;
    end else begin
      enable_prev <= enable;
      data_valid  <= 1'b0;
      if (state == IDLE) begin
        tick  <= '0;
        phase <= '0;
      end else if (us_tick) begin
        tick  <= '0;
        phase <= phase + 1'b1;
      end else begin
        tick <= tick + 1'b1;
      end

      case (state)
        IDLE: begin
          if (start) begin
            state     <= START_LOW;
            drive_low <= 1'b1;
            error     <= 1'b0;
            busy      <= 1'b1;
          end
        end
        DONE, ERROR: begin
          if (!enable) state <= IDLE;
        end
        default: begin
          if (!enable) begin
            state     <= IDLE;
            drive_low <= 1'b0;
            busy      <= 1'b0;
            tick      <= '0;
            phase     <= '0;
          end else begin
            case (state)
              START_LOW: begin
                if (us_tick && phase == PHASE_W'(START_LOW_US - 1)) begin
                  state     <= RELEASE;
                  drive_low <= 1'b0;
                  tick      <= '0;
                  phase     <= '0;
                end
              end
              RELEASE, RESP_LOW, RESP_HIGH, BIT_LOW, BIT_HIGH: begin
                if ((state == RELEASE || state == RESP_HIGH || state == BIT_HIGH) && fall) begin
                  tick  <= '0;
                  phase <= '0;
                  if (state == RELEASE) begin
                    state <= RESP_LOW;
                  end else if (state == RESP_HIGH) begin
                    state   <= BIT_LOW;
                    bit_idx <= 6'd39;
                  end else begin
                    shift_reg[bit_idx] <= (phase > PHASE_W'(BIT_THRESH_US));
                    if (bit_idx == 6'd0) begin
                      state <= CHECK;
                    end else begin
                      bit_idx <= bit_idx - 1'b1;
                      state   <= BIT_LOW;
                    end
                  end
                end else if ((state == RESP_LOW || state == BIT_LOW) && rise) begin
                  tick  <= '0;
                  phase <= '0;
                  state <= (state == RESP_LOW) ? RESP_HIGH : BIT_HIGH;
                end else if (timed_out) begin
                  state <= ERROR;
                  error <= 1'b1;
                  busy  <= 1'b0;
                  tick  <= '0;
                  phase <= '0;
                end
              end
              CHECK: begin
                busy  <= 1'b0;
                tick  <= '0;
                phase <= '0;
                if (shift_reg[7:0] == sum) begin
                  data_sensor <= shift_reg;
                  data_valid  <= 1'b1;
                  state       <= DONE;
                end else begin
                  error <= 1'b1;
                  state <= ERROR;
                end
              end
              default: ;
            endcase
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dht11_sensor_interface.sv
// Bench for dht11_sensor_interface: a timed sensor model answers each start
// pulse; a monitor checks every data_valid pulse against queued frames.
`timescale 1ns/1ps
module tb_dht11_sensor_interface;

  localparam int CLK_NS    = 20;
  localparam int TICKS     = 2;
  localparam int START_US  = 20;
  localparam int THRESH_US = 40;
  localparam int TMO_US    = 200;
  localparam int US_NS     = TICKS * CLK_NS;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        enable = 1'b0;
  logic        sensor_low = 1'b0;
  wire         dht_data;
  logic [39:0] data_sensor;
  logic        data_valid;
  logic        error;
  logic        busy;
  logic [3:0]  fsm_state;

  int          checks = 0;
  int          errors = 0;
  int          valid_count = 0;
  logic [39:0] exp_q[$];
  logic [39:0] last_good = '0;

  assign dht_data = sensor_low ? 1'b0 : 1'bz;
  pullup (dht_data);

  dht11_sensor_interface #(
    .TICKS_PER_US (TICKS),
    .START_LOW_US (START_US),
    .BIT_THRESH_US(THRESH_US),
    .TIMEOUT_US   (TMO_US)
  ) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .enable     (enable),
    .dht_data   (dht_data),
    .data_sensor(data_sensor),
    .data_valid (data_valid),
    .error      (error),
    .busy       (busy),
    .fsm_state  (fsm_state)
  );

  // Clock and watchdog
  always #(CLK_NS / 2) clock = ~clock;

  initial begin
    #(150000 * CLK_NS);
    $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h", name, actual, expected);
    end
  endtask

  // Reference model: a frame is good when its last byte is the byte sum mod 256
  function automatic bit frame_good(input logic [39:0] f);
    int s = 0;
    for (int b = 1; b < 5; b++) s += int'(f[b*8 +: 8]);
    return (s % 256) == int'(f[7:0]);
  endfunction

  function automatic logic [39:0] make_frame(input bit good);
    logic [7:0] b[4];
    int s = 0;
    logic [7:0] cs;
    for (int i = 0; i < 4; i++) begin
      b[i] = 8'($urandom_range(0, 255));
      s += int'(b[i]);
    end
    cs = 8'(s % 256);
    if (!good) cs = 8'(int'(cs) + int'($urandom_range(1, 255)));
    return {b[0], b[1], b[2], b[3], cs};
  endfunction

  // Scoreboard monitor
  always @(negedge clock) begin
    if (reset_n && data_valid) begin
      valid_count++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_valid: data_sensor=%h, required no pulse", data_sensor);
      end else begin
        logic [39:0] exp;
        exp = exp_q.pop_front();
        if (data_sensor !== exp) begin
          errors++;
          $display("FAIL frame_data: actual=%h required=%h", data_sensor, exp);
        end
      end
    end
  end

  // Sensor model driver tasks
  task automatic wait_start(output int low_cycles);
    int k = 0;
    low_cycles = 0;
    while (dht_data !== 1'b0 && k < 10) begin
      @(negedge clock);
      k++;
    end
    check("start_seen", {63'd0, dht_data}, 64'd0);
    check("start_clears_error", {62'd0, error, busy}, 64'd1);
    while (dht_data === 1'b0 && low_cycles < 4 * START_US * TICKS) begin
      low_cycles++;
      @(negedge clock);
    end
  endtask

  task automatic send_frame(input logic [39:0] f, input int abort_bit);
    int hi;
    #5;
    #(20 * US_NS);
    sensor_low = 1'b1; #(80 * US_NS);
    sensor_low = 1'b0; #(80 * US_NS);
    for (int i = 39; i >= 0; i--) begin
      sensor_low = 1'b1; #(50 * US_NS);
      sensor_low = 1'b0;
      hi = f[i] ? 70 : 27;
      if (i == abort_bit) begin
        #((hi / 2) * US_NS);
        enable = 1'b0;
        @(negedge clock);
        return;
      end
      #(hi * US_NS);
    end
    sensor_low = 1'b1; #(50 * US_NS);
    sensor_low = 1'b0;
    @(negedge clock);
  endtask

  task automatic run_read(input logic [39:0] f, input int hold_cycles);
    int low;
    int restarts = 0;
    int valid_before;
    bit good;
    good = frame_good(f);
    valid_before = valid_count;
    @(negedge clock);
    enable = 1'b1;
    wait_start(low);
    check("start_low_cycles", 64'(low), 64'(START_US * TICKS));
    if (good) begin
      exp_q.push_back(f);
      last_good = f;
    end
    send_frame(f, -1);
    repeat (4) @(negedge clock);
    check("done_busy", {63'd0, busy}, 64'd0);
    check("done_error", {63'd0, error}, {63'd0, !good});
    check("done_data_held", {24'd0, data_sensor}, {24'd0, last_good});
    for (int c = 0; c < hold_cycles; c++) begin
      @(negedge clock);
      if (busy || dht_data !== 1'b1) restarts++;
    end
    check("hold_no_restart", 64'(restarts), 64'd0);
    enable = 1'b0;
    repeat (3) @(negedge clock);
    check("error_kept_after_enable_low", {63'd0, error}, {63'd0, !good});
    check("valid_pulses", 64'(valid_count - valid_before), 64'(good));
  endtask

  initial begin
    int low;
    int n;
    logic [39:0] f;

    // Reset state
    repeat (3) @(negedge clock);
    check("reset_outputs", {data_sensor, 21'd0, data_valid, error, busy}, 64'd0);
    check("reset_line_released", {63'd0, dht_data}, 64'd1);
    reset_n = 1'b1;
    repeat (3) @(negedge clock);

    // Good frame, then bad checksum keeping the previous data
    run_read(40'h3700190050, 20);
    run_read(40'h3700190051, 50);

    // Absent sensor: timeout measured from line release
    @(negedge clock);
    enable = 1'b1;
    wait_start(low);
    check("nosensor_start_low", 64'(low), 64'(START_US * TICKS));
    n = 0;
    while (error !== 1'b1 && n < 2 * TMO_US * TICKS) begin
      n++;
      @(negedge clock);
    end
    check("timeout_cycles", 64'(n), 64'(TMO_US * TICKS));
    check("timeout_busy", {63'd0, busy}, 64'd0);
    check("timeout_data_held", {24'd0, data_sensor}, {24'd0, last_good});
    enable = 1'b0;
    repeat (3) @(negedge clock);

    // One read per enable level, even when held for 2 ms
    run_read(make_frame(1'b1), 2000 * TICKS);

    // Abort in the middle of bit 20
    f = make_frame(1'b1);
    @(negedge clock);
    enable = 1'b1;
    wait_start(low);
    send_frame(f, 20);
    check("abort_busy", {63'd0, busy}, 64'd0);
    check("abort_line", {63'd0, dht_data}, 64'd1);
    check("abort_error", {63'd0, error}, 64'd0);
    check("abort_data_held", {24'd0, data_sensor}, {24'd0, last_good});
    repeat (20) @(negedge clock);

    // Asynchronous reset during the start pulse
    @(negedge clock);
    enable = 1'b1;
    repeat (10) @(negedge clock);
    check("start_pulse_driven", {63'd0, dht_data}, 64'd0);
    #3;
    reset_n = 1'b0;
    #1;
    last_good = '0;
    check("async_reset_outputs", {data_sensor, 21'd0, data_valid, error, busy}, 64'd0);
    check("async_reset_line", {63'd0, dht_data}, 64'd1);
    enable = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
    repeat (3) @(negedge clock);

    // Randomised frames, mostly good
    for (int t = 0; t < 3; t++) begin
      run_read(make_frame($urandom_range(0, 3) != 0), 0);
    end

    repeat (5) @(negedge clock);
    check("pending_expected", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dht11_sensor_interface.md
Name: dht11_sensor_interface

Overview:
Single-wire driver for the DHT11 temperature/humidity sensor. It sits directly downstream of the controller unit. It consumes the controller's sensor-enable level (inout_sensor), runs one DHT11 read per enable assertion and returns the 40-bit frame, which the controller samples as data_sensor. It also reports validity and checksum/timeout errors.

Parameters:
TICKS_PER_US, 50, clock cycles per microsecond (50 MHz board clock)
START_LOW_US, 18000, host start pulse low time in µs
BIT_THRESH_US, 40, high-phase length above which a bit is 1
TIMEOUT_US, 200, max wait per line phase before error

Ports:
clock  in  1  50 MHz system clock
reset_n  in  1  asynchronous, active-low reset
enable  in  1  level request from controller (inout_sensor); rising edge starts a read
dht_data  inout  1  sensor line; driven 0 when host pulls low, else Z (external pull-up)
data_sensor  out  40  last good frame {hum_int, hum_dec, temp_int, temp_dec, checksum}
data_valid  out  1  one-cycle pulse on a good frame
error  out  1  level; set on timeout or checksum fail, cleared on next start
busy  out  1  high from start until DONE/ERROR

Behaviour:
- Reset (async, reset_n=0): state IDLE; dht_data=Z; data_sensor=0; data_valid=0; error=0; busy=0; all counters 0.
- dht_data input goes through a 2-FF synchroniser. All edge detection uses the synchronised value, so there are 2 cycles of input latency.
- enable is edge-detected internally (registered copy). Start condition: enable=1 and previous=0, while in IDLE.
- One µs tick counter (0..TICKS_PER_US-1) runs whenever state≠IDLE. Phase counters count µs.
- States and transitions:
  IDLE: line Z. On start -> START_LOW; clear error; set busy.
  START_LOW: drive 0 for START_LOW_US -> RELEASE.
  RELEASE: line Z; wait for sensor low -> RESP_LOW.
  RESP_LOW: wait for high -> RESP_HIGH.
  RESP_HIGH: wait for low -> BIT_LOW; bit index=39.
  BIT_LOW: wait for high -> BIT_HIGH; clear high counter.
  BIT_HIGH: count µs while high. On falling edge: bit = (count > BIT_THRESH_US); shift into shift_reg[index], MSB first. If index=0 -> CHECK, else index-1 -> BIT_LOW.
  CHECK (1 cycle): good if shift[7:0] == (shift[39:32]+shift[31:24]+shift[23:16]+shift[15:8]) mod 256. Good -> data_sensor<=shift, data_valid=1 for one cycle, -> DONE. Bad -> error=1, data_sensor unchanged, -> ERROR.
  DONE / ERROR: busy=0; line Z; stay until enable=0, then -> IDLE. Only one read per enable assertion.
- Timeout: in RELEASE, RESP_LOW, RESP_HIGH, BIT_LOW, BIT_HIGH, phase counter ≥ TIMEOUT_US -> ERROR with error=1. Phase counter resets on every state change.
- enable falling while busy (any state START_LOW..CHECK): abort -> IDLE next cycle. Line released, busy=0, no data_valid, error unchanged, data_sensor unchanged.
- Checksum sum is 8-bit wrap-around; carry is discarded.
- data_sensor is stable whenever busy=0. The controller holds enable ≫ one transaction (~23 ms), so data is ready before it samples.
- Host never drives 1 on dht_data.

Test Plan:
Bench settings: START_LOW_US=20 override; behavioural sensor model (80/80 µs response, 50 µs bit low, 27 µs = 0, 70 µs = 1).
1. Good frame: pulse enable, model sends 0x37_00_19_00_50 -> after last bit, one data_valid pulse; data_sensor=40'h3700190050; error=0; line low exactly 20×50 cycles at start.
2. Bad checksum: model sends 0x37_00_19_00_51 -> no data_valid; error=1; data_sensor keeps 40'h3700190050 from test 1; state ERROR until enable=0.
3. No sensor (line stays high after release) -> error=1 after 200 µs (10000 cycles) in RELEASE; busy=0.
4. Abort: drop enable in the middle of bit 20 -> IDLE next cycle; dht_data Z; no valid; data_sensor unchanged.
5. Hold enable high 2 ms after a good frame -> exactly one transaction, one data_valid; a new rising edge starts a second read and clears error.
6. Assert reset_n=0 during START_LOW -> outputs immediately at reset values; dht_data Z without waiting for a clock edge.
